jtag_dbg_bridge: RTL



---
 rtl/jtag_dbg_pkg.sv | 30 +++
 rtl/jtag_dbg_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/jtag_dbg_pkg.sv
// Shared encodings for the JTAG debug bridge: command ops, FSM states,
// dbg_status bit positions and the IR-select constants.
package jtag_dbg_pkg;

  typedef enum logic [1:0] {
    OP_SETADDR = 2'b00,
    OP_READ    = 2'b01,
    OP_ARMWR   = 2'b10,
    OP_BAD     = 2'b11
  } dbg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WR_ARMED = 2'b01,
    ST_RD_BUS   = 2'b10,
    ST_WR_BUS   = 2'b11
  } dbg_state_e;

  localparam int unsigned STAT_BUSY        = 7;
  localparam int unsigned STAT_WR_ARMED    = 6;
  localparam int unsigned STAT_ERR_TIMEOUT = 5;
  localparam int unsigned STAT_ERR_OVERRUN = 4;
  localparam int unsigned STAT_ERR_BADOP   = 3;

  localparam logic DBG_SEL_CMD  = 1'b0;
  localparam logic DBG_SEL_DATA = 1'b1;

  localparam logic [3:0] BUS_WEN_ALL = 4'hF;

endpackage

// File: rtl/jtag_dbg_bridge.sv
// Converts JTAG debug-register updates into single-word bus reads/writes.
// Build option JTAG_DBG_AUTOINC_EN: post-access address increment and streaming writes.
module jtag_dbg_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dbg_word,
  input  logic        dbg_sel,
  input  logic        dbg_strobe,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wen,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic [31:0] dbg_rdata,
  output logic [7:0]  dbg_status
);

`ifdef JTAG_DBG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  dbg_state_e  r_state;
  dbg_state_e  w_next_state;

  logic        r_strobe;
  logic        r_sel;
  logic [31:0] r_word;
  logic [29:0] r_addr_w;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;
  logic        r_err_timeout;
  logic        r_err_overrun;
  logic        r_err_badop;

  dbg_op_e     w_op;
  logic        w_cmd;
  logic        w_data;
  logic        w_busy;
  logic        w_accept_cmd;
  logic        w_wr_launch;
  logic        w_done;
  logic        w_timeout;

  assign w_op         = dbg_op_e'(r_word[1:0]);
  assign w_cmd        = r_strobe && (r_sel == DBG_SEL_CMD);
  assign w_data       = r_strobe && (r_sel == DBG_SEL_DATA);
  assign w_busy       = (r_state == ST_RD_BUS) || (r_state == ST_WR_BUS);
  assign w_accept_cmd = w_cmd && !w_busy;
  assign w_wr_launch  = w_data && (r_state == ST_WR_ARMED);
  assign w_done       = w_busy && bus_ready;
  // The counter holds request cycles already spent, so the last allowed one is T-1.
  assign w_timeout    = w_busy && !bus_ready && (r_cnt == TIMEOUT_LAST);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_WR_ARMED: begin
        if (w_cmd) begin
          case (w_op)
            OP_READ:  w_next_state = ST_RD_BUS;
            OP_ARMWR: w_next_state = ST_WR_ARMED;
            default:  w_next_state = ST_IDLE;
          endcase
        end else if (w_wr_launch) begin
          w_next_state = ST_WR_BUS;
        end
      end
      ST_RD_BUS: begin
        if (bus_ready || w_timeout) w_next_state = ST_IDLE;
      end
      ST_WR_BUS: begin
        if (bus_ready)      w_next_state = AUTOINC ? ST_WR_ARMED : ST_IDLE;
        else if (w_timeout) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus_ren    = (r_state == ST_RD_BUS);
    bus_wen    = (r_state == ST_WR_BUS) ? BUS_WEN_ALL : 4'h0;
    dbg_status = 8'h00;
    dbg_status[STAT_BUSY]        = w_busy;
    dbg_status[STAT_WR_ARMED]    = (r_state == ST_WR_ARMED);
    dbg_status[STAT_ERR_TIMEOUT] = r_err_timeout;
    dbg_status[STAT_ERR_OVERRUN] = r_err_overrun;
    dbg_status[STAT_ERR_BADOP]   = r_err_badop;
  end

  assign bus_addr  = {r_addr_w, 2'b00};
  assign bus_wdata = r_wdata;
  assign dbg_rdata = r_rdata;

  // Datapath: update capture, address, data, timeout counter and sticky errors
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_strobe      <= 1'b0;
      r_sel         <= 1'b0;
      r_word        <= '0;
      r_addr_w      <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_cnt         <= '0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_badop   <= 1'b0;
    end else begin
      r_strobe <= dbg_strobe;
      r_sel    <= dbg_sel;
      r_word   <= dbg_word;

      r_cnt <= (w_busy && !bus_ready) ? r_cnt + 8'd1 : 8'd0;

      if (w_accept_cmd && (w_op != OP_BAD)) r_addr_w <= r_word[31:2];
      else if (w_done && AUTOINC)           r_addr_w <= r_addr_w + 30'd1;

      if (w_wr_launch) r_wdata <= r_word;

      if ((r_state == ST_RD_BUS) && bus_ready) r_rdata <= bus_rdata;

      if (w_accept_cmd && (w_op == OP_SETADDR)) begin
        r_err_timeout <= 1'b0;
        r_err_overrun <= 1'b0;
        r_err_badop   <= 1'b0;
      end else begin
        if (w_timeout)          r_err_timeout <= 1'b1;
        if (w_busy && r_strobe) r_err_overrun <= 1'b1;
        if ((w_accept_cmd && (w_op == OP_BAD)) || (w_data && (r_state == ST_IDLE)))
          r_err_badop <= 1'b1;
      end
    end
  end

endmodule
